// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: two-flop sync, per-input debounce, Gray-code
// decode with detent accumulation, and a wrap/saturate position counter.
module quad_encoder_counter #(
    parameter int CNT_W            = 8,
    parameter int MAX_COUNT        = 2**CNT_W - 1,
    parameter int DEB_BITS         = 11,
    parameter int STEPS_PER_DETENT = 1,
    parameter bit SATURATE         = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             err
);

    localparam logic [DEB_BITS-1:0] DEB_MAX = '1;
    localparam logic [CNT_W-1:0]    MAX_C   = CNT_W'(MAX_COUNT);
    localparam logic signed [3:0]   STEPS   = 4'(STEPS_PER_DETENT);

    // Bit 1 carries A, bit 0 carries B throughout.
    logic [1:0]          r_s1, r_s2, r_s3, r_stable, r_prev;
    logic [DEB_BITS-1:0] r_deb [2];
    logic [1:0]          w_diff;

    logic                w_up_edge, w_dn_edge, w_illegal;
    logic signed [3:0]   r_acc;
    logic                r_req_up, r_req_dn;
    logic [CNT_W-1:0]    r_count;
    logic                r_up, r_dn, r_err;

    assign w_diff = r_s2 ^ r_s3;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= 2'b11;
            r_s2     <= 2'b11;
            r_s3     <= 2'b11;
            r_stable <= 2'b11;
            r_prev   <= 2'b11;
            r_deb[0] <= '0;
            r_deb[1] <= '0;
        end else begin
            r_s1 <= {a_in, b_in};
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            for (int i = 0; i < 2; i++) begin
                if (w_diff[i])
                    r_deb[i] <= '0;
                else if (r_deb[i] != DEB_MAX)
                    r_deb[i] <= r_deb[i] + 1'b1;
                if (!w_diff[i] && r_deb[i] == DEB_MAX)
                    r_stable[i] <= r_s2[i];
            end
            r_prev <= r_stable;
        end
    end

    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    always_comb begin
        w_up_edge = 1'b0;
        w_dn_edge = 1'b0;
        w_illegal = &(r_prev ^ r_stable);
        case ({r_prev, r_stable})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up_edge = 1'b1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: w_dn_edge = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_req_up <= 1'b0;
            r_req_dn <= 1'b0;
            r_count  <= '0;
            r_up     <= 1'b0;
            r_dn     <= 1'b0;
            r_err    <= 1'b0;
        end else if (clear) begin
            r_acc    <= '0;
            r_req_up <= 1'b0;
            r_req_dn <= 1'b0;
            r_count  <= '0;
            r_up     <= 1'b0;
            r_dn     <= 1'b0;
            r_err    <= 1'b0;
        end else if (load) begin
            r_acc    <= '0;
            r_req_up <= 1'b0;
            r_req_dn <= 1'b0;
            r_count  <= (load_value > MAX_C) ? MAX_C : load_value;
            r_up     <= 1'b0;
            r_dn     <= 1'b0;
            if (w_illegal)
                r_err <= 1'b1;
        end else begin
            r_req_up <= 1'b0;
            r_req_dn <= 1'b0;
            r_up     <= 1'b0;
            r_dn     <= 1'b0;

            if (w_illegal) begin
                r_err <= 1'b1;
                r_acc <= '0;
            end else if (w_up_edge) begin
                if (r_acc + 4'sd1 == STEPS) begin
                    r_acc    <= '0;
                    r_req_up <= 1'b1;
                end else begin
                    r_acc <= r_acc + 4'sd1;
                end
            end else if (w_dn_edge) begin
                if (r_acc - 4'sd1 == -STEPS) begin
                    r_acc    <= '0;
                    r_req_dn <= 1'b1;
                end else begin
                    r_acc <= r_acc - 4'sd1;
                end
            end

            // A saturation hold leaves the count alone and emits no pulse.
            if (r_req_up) begin
                if (r_count == MAX_C) begin
                    if (!SATURATE) begin
                        r_count <= '0;
                        r_up    <= 1'b1;
                    end
                end else begin
                    r_count <= r_count + 1'b1;
                    r_up    <= 1'b1;
                end
            end else if (r_req_dn) begin
                if (r_count == '0) begin
                    if (!SATURATE) begin
                        r_count <= MAX_C;
                        r_dn    <= 1'b1;
                    end
                end else begin
                    r_count <= r_count - 1'b1;
                    r_dn    <= 1'b1;
                end
            end
        end
    end

    assign count      = r_count;
    assign up_pulse   = r_up;
    assign down_pulse = r_dn;
    assign err        = r_err;

endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
Parametrised single-channel quadrature rotary-encoder front end. Takes raw A/B pin levels from the pull-up SB_IO cells and synchronises and debounces them. Decodes Gray-code transitions and keeps a bounded position counter. Adds several things the first-generation decoder lacked: detent division, wrap or saturate limits, load and clear, direction pulses, and a sticky error flag.

Parameters:
CNT_W, 8, position counter width in bits.
MAX_COUNT, 2**CNT_W-1, top of count range; range is 0..MAX_COUNT.
DEB_BITS, 11, debounce counter width; an input must be stable 2**DEB_BITS cycles.
STEPS_PER_DETENT, 1, quadrature edges per count step; legal values 1, 2, 4.
SATURATE, 0, 0 = wrap at limits, 1 = clamp at limits.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
a_in  input  1  raw encoder A level (idle high)
b_in  input  1  raw encoder B level (idle high)
clear  input  1  synchronous: zero count, accumulator, err
load  input  1  synchronous: load count from load_value
load_value  input  CNT_W  value for load
count  output  CNT_W  position
up_pulse  output  1  one-cycle pulse when count incremented
down_pulse  output  1  one-cycle pulse when count decremented
err  output  1  sticky illegal-transition flag

Behaviour:
- Reset (rst_n low, async):
  - count=0, up_pulse=0, down_pulse=0, err=0.
  - Accumulator=0, debounce counters=0.
  - Sync flops, stable A/B and previous A/B reset to 1.
- Sync: per input, two flops s1,s2 plus a delayed copy s3. diff = s2^s3.
- Debounce, per input:
  - diff=1: counter <= 0.
  - diff=0: counter increments, saturating at 2**DEB_BITS-1.
  - stable <= s2 only when counter is all-ones and diff=0.
  - Latency: stable changes exactly 2**DEB_BITS+2 edges after the edge that first samples the new raw level into s1.
  - A raw pulse shorter than 2**DEB_BITS cycles never reaches stable.
- Decode: compare prev {A,B} with current stable {A,B}; prev <= stable every cycle.
  - Up sequence 00->10->11->01->00.
  - Down sequence is the reverse.
  - No change = idle.
  - Both bits changing = illegal: err <= 1, accumulator <= 0, count unchanged.
- Accumulator: signed 4-bit; +1 on an up edge, -1 on a down edge.
  - At +STEPS_PER_DETENT: request step up, acc <= 0.
  - At -STEPS_PER_DETENT: request step down, acc <= 0.
  - STEPS_PER_DETENT=1 means every edge is a step.
- Count update (registered, one edge after the decode edge), priority clear > load > step:
  - clear: count=0, acc=0, err=0, no pulse.
  - load: count = min(load_value, MAX_COUNT), acc=0, no pulse.
  - Step up: count==MAX_COUNT -> hold if SATURATE=1, else go to 0. Otherwise count+1.
  - Step down: count==0 -> hold if SATURATE=1, else go to MAX_COUNT. Otherwise count-1.
- Pulses: up_pulse/down_pulse are registered with count and assert for exactly one cycle, only when count actually changed (a wrap counts as a change; a saturation hold does not). Never both high.
- Total latency: clean raw edge to count update = 2**DEB_BITS+4 edges.
- clear/load arriving in the same cycle as a step request: step is discarded.
- err remains set until clear or reset. Decoding continues while err=1.
- Reset mid-debounce: all state returns to reset values; no pulse is emitted on release.

Test Plan:
1. Reset, defaults (DEB_BITS=2, CNT_W=4, MAX_COUNT=9): hold rst_n low, toggle inputs -> count=0, err=0, pulses 0. Release with a_in=b_in=1 -> no change.
2. STEPS=1: drive A/B through 11->01->00->10->11, each level held 8 cycles -> count 0,1,2,3,4 in order, four single-cycle up_pulse, each 8 edges after its raw edge. Reverse sequence -> back to 0 with four down_pulse.
3. STEPS=4: one full up cycle -> count=1, one up_pulse. Then 3 edges up and 3 edges down -> count stays 1, no pulse.
4. Wrap vs saturate, SATURATE=0: load 9, one up step -> 0 with up_pulse; one down step -> 9 with down_pulse. SATURATE=1: load 9, step up -> stays 9, no pulse. Load 15 -> count=9.
5. Glitch/error: 3-cycle low glitch on a_in -> count unchanged, no pulse. Flip a_in and b_in on the same edge, held 8 cycles -> err=1, count unchanged. clear -> err=0, count=0. clear and load together -> count=0.
6. Async reset mid-operation: assert rst_n 2 cycles into a debounce window, then release -> count=0, no pulse. The next legal transition decodes normally.
